// File: rtl/mem_req_arbiter.sv
// Shares one single-cycle-latency RAM port between instruction fetch and load/store requesters.
// Optional macro ARB_RR_EN selects round-robin tie-breaking; otherwise LSU wins ties.
module mem_req_arbiter #(
   parameter int                 WIDTH = 64,
   parameter logic [WIDTH-1:0]   BASE  = 64'h0000_0000_8000_0000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 if_req_valid,
   output logic                 if_req_ready,
   input  logic [WIDTH-1:0]     if_req_addr,
   output logic                 if_resp_valid,
   input  logic                 if_resp_ready,
   output logic [WIDTH-1:0]     if_resp_data,
   input  logic                 ls_req_valid,
   output logic                 ls_req_ready,
   input  logic [WIDTH-1:0]     ls_req_addr,
   input  logic                 ls_req_wen,
   input  logic [WIDTH-1:0]     ls_req_wdata,
   input  logic [WIDTH-1:0]     ls_req_wmask,
   output logic                 ls_resp_valid,
   input  logic                 ls_resp_ready,
   output logic [WIDTH-1:0]     ls_resp_rdata,
   output logic                 ram_en,
   output logic [WIDTH-1:0]     ram_idx,
   output logic                 ram_wen,
   output logic [WIDTH-1:0]     ram_wdata,
   output logic [WIDTH-1:0]     ram_wmask,
   input  logic [WIDTH-1:0]     ram_rdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_LS = 1'b1;

   state_t           state, state_nxt;
   logic             owner;
   logic             wen_q;
   logic [WIDTH-1:0] addr_q, wdata_q, wmask_q, resp_q;
   logic [WIDTH-1:0] offset;
   logic             grant_if, grant_ls, req_hs;
   logic             access, resp_valid, resp_ready_sel;

`ifdef ARB_RR_EN
   logic             last_grant;
`endif

   function automatic logic [WIDTH-1:0] shape_resp(input logic             own,
                                                   input logic             wen,
                                                   input logic             half,
                                                   input logic [WIDTH-1:0] rdata);
      logic [WIDTH-1:0] res;
      res = '0;
      if (own == OWN_IF)
         res[31:0] = half ? rdata[63:32] : rdata[31:0];
      else if (!wen)
         res = rdata;
      return res;
   endfunction

   // Grant is purely combinational and only offered in IDLE outside reset
   always_comb begin
      grant_if = 1'b0;
      grant_ls = 1'b0;
      if (state == IDLE && !rst) begin
         if (if_req_valid && ls_req_valid) begin
`ifdef ARB_RR_EN
            if (last_grant == OWN_LS) grant_if = 1'b1;
            else                      grant_ls = 1'b1;
`else
            grant_ls = 1'b1;
`endif
         end else if (if_req_valid) begin
            grant_if = 1'b1;
         end else if (ls_req_valid) begin
            grant_ls = 1'b1;
         end
      end
   end

   assign if_req_ready   = grant_if;
   assign ls_req_ready   = grant_ls;
   assign req_hs         = grant_if | grant_ls;
   assign resp_ready_sel = (owner == OWN_LS) ? ls_resp_ready : if_resp_ready;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req_hs) state_nxt = ACCESS;
         ACCESS:  state_nxt = CAPTURE;
         CAPTURE: state_nxt = RESP;
         RESP:    if (resp_ready_sel) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         owner <= OWN_IF;
         wen_q <= 1'b0;
      end else begin
         state <= state_nxt;
         if (req_hs) begin
            owner <= grant_ls ? OWN_LS : OWN_IF;
            wen_q <= grant_ls & ls_req_wen;
         end
      end
   end

`ifdef ARB_RR_EN
   always_ff @(posedge clk) begin
      if (rst)         last_grant <= OWN_LS;
      else if (req_hs) last_grant <= grant_ls ? OWN_LS : OWN_IF;
   end
`endif

   // Request payload and response data carry no reset; their outputs are gated instead
   always_ff @(posedge clk) begin
      if (req_hs) begin
         addr_q  <= grant_ls ? ls_req_addr : if_req_addr;
         wdata_q <= ls_req_wdata;
         wmask_q <= ls_req_wmask;
      end
      if (state == CAPTURE)
         resp_q <= shape_resp(owner, wen_q, addr_q[2], ram_rdata);
   end

   assign offset     = addr_q - BASE;
   assign access     = (state == ACCESS) && !rst;
   assign resp_valid = (state == RESP) && !rst;

   assign ram_en    = access;
   assign ram_wen   = access && wen_q;
   assign ram_idx   = access ? (offset >> 3) : '0;
   assign ram_wdata = (access && wen_q) ? wdata_q : '0;
   assign ram_wmask = (access && wen_q) ? wmask_q : '0;

   assign if_resp_valid = resp_valid && (owner == OWN_IF);
   assign ls_resp_valid = resp_valid && (owner == OWN_LS);
   assign if_resp_data  = if_resp_valid ? resp_q : '0;
   assign ls_resp_rdata = ls_resp_valid ? resp_q : '0;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Scoreboard bench for mem_req_arbiter with a behavioural single-cycle RAM.
module tb_mem_req_arbiter;

   localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;
   localparam logic [63:0] W0   = 64'h1111_2222_3333_4444;
   localparam logic [63:0] W1   = 64'h0A0B_0C0D_0E0F_1011;
   localparam logic [63:0] W2   = 64'h0123_4567_89AB_CDEF;
   localparam logic [63:0] W3   = 64'hAAAA_AAAA_AAAA_AAAA;
   localparam logic [63:0] W15  = 64'h5555_6666_7777_8888;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_req_valid = 1'b0, if_req_ready;
   logic [63:0] if_req_addr = '0;
   logic        if_resp_valid, if_resp_ready = 1'b1;
   logic [63:0] if_resp_data;
   logic        ls_req_valid = 1'b0, ls_req_ready;
   logic [63:0] ls_req_addr = '0;
   logic        ls_req_wen = 1'b0;
   logic [63:0] ls_req_wdata = '0, ls_req_wmask = '0;
   logic        ls_resp_valid, ls_resp_ready = 1'b1;
   logic [63:0] ls_resp_rdata;
   logic        ram_en, ram_wen;
   logic [63:0] ram_idx, ram_wdata, ram_wmask;
   logic [63:0] ram_rdata;

   logic [63:0] mem [16];
   bit          preload = 1'b1;

   int          n_chk = 0;
   int          n_fail = 0;
   logic [63:0] if_q[$];
   logic [63:0] ls_q[$];

   mem_req_arbiter dut (
      .clk(clk), .rst(rst),
      .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
      .if_resp_valid(if_resp_valid), .if_resp_ready(if_resp_ready), .if_resp_data(if_resp_data),
      .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_addr(ls_req_addr),
      .ls_req_wen(ls_req_wen), .ls_req_wdata(ls_req_wdata), .ls_req_wmask(ls_req_wmask),
      .ls_resp_valid(ls_resp_valid), .ls_resp_ready(ls_resp_ready), .ls_resp_rdata(ls_resp_rdata),
      .ram_en(ram_en), .ram_idx(ram_idx), .ram_wen(ram_wen),
      .ram_wdata(ram_wdata), .ram_wmask(ram_wmask), .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 16; i++) mem[i] <= 64'(i) * 64'h0101_0101_0101_0101;
         mem[0]  <= W0;
         mem[1]  <= W1;
         mem[2]  <= W2;
         mem[3]  <= W3;
         mem[15] <= W15;
         ram_rdata <= '0;
      end else if (ram_en) begin
         ram_rdata <= mem[ram_idx[3:0]];
         if (ram_wen)
            mem[ram_idx[3:0]] <= (mem[ram_idx[3:0]] & ~ram_wmask) | (ram_wdata & ram_wmask);
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (if_resp_valid && if_resp_ready) begin
            if (if_q.size() == 0) chk("if_resp_unexpected", 64'd1, 64'd0);
            else                  chk("if_resp_data", if_resp_data, if_q.pop_front());
         end
         if (ls_resp_valid && ls_resp_ready) begin
            if (ls_q.size() == 0) chk("ls_resp_unexpected", 64'd1, 64'd0);
            else                  chk("ls_resp_rdata", ls_resp_rdata, ls_q.pop_front());
         end
      end
   end

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_if_req_ready"},  if_req_ready,  0);
      chk({tag, "_ls_req_ready"},  ls_req_ready,  0);
      chk({tag, "_if_resp_valid"}, if_resp_valid, 0);
      chk({tag, "_ls_resp_valid"}, ls_resp_valid, 0);
      chk({tag, "_ram_en"},        ram_en,        0);
      chk({tag, "_ram_wen"},       ram_wen,       0);
      chk({tag, "_ram_idx"},       ram_idx,       0);
      chk({tag, "_ram_wdata"},     ram_wdata,     0);
      chk({tag, "_ram_wmask"},     ram_wmask,     0);
      chk({tag, "_if_resp_data"},  if_resp_data,  0);
      chk({tag, "_ls_resp_rdata"}, ls_resp_rdata, 0);
   endtask

   // Handshake at cycle t, RAM access at t+1, response visible from t+3; returns at negedge t+3.
   task automatic issue(input bit is_ls, input logic [63:0] addr, input bit wen,
                        input logic [63:0] wdata, input logic [63:0] wmask,
                        input logic [63:0] exp_idx, input logic [63:0] exp_resp);
      @(posedge clk); #1;
      if (is_ls) begin
         ls_req_valid = 1'b1; ls_req_addr = addr; ls_req_wen = wen;
         ls_req_wdata = wdata; ls_req_wmask = wmask;
         ls_q.push_back(exp_resp);
      end else begin
         if_req_valid = 1'b1; if_req_addr = addr;
         if_q.push_back(exp_resp);
      end
      @(negedge clk);
      chk(is_ls ? "ls_req_ready" : "if_req_ready", is_ls ? ls_req_ready : if_req_ready, 1);
      @(posedge clk); #1;
      if_req_valid = 1'b0; ls_req_valid = 1'b0;
      if_req_addr = '1; ls_req_addr = '1; ls_req_wen = ~wen;
      ls_req_wdata = ~wdata; ls_req_wmask = ~wmask;
      @(negedge clk);
      chk("access_ram_en",  ram_en,  1);
      chk("access_ram_idx", ram_idx, exp_idx);
      chk("access_ram_wen", ram_wen, wen);
      if (wen) begin
         chk("access_ram_wdata", ram_wdata, wdata);
         chk("access_ram_wmask", ram_wmask, wmask);
      end
      @(negedge clk);
      chk("capture_no_resp", if_resp_valid | ls_resp_valid, 0);
      chk("capture_ram_en",  ram_en, 0);
      @(negedge clk);
      chk(is_ls ? "ls_resp_valid" : "if_resp_valid", is_ls ? ls_resp_valid : if_resp_valid, 1);
      chk("other_resp_valid", is_ls ? if_resp_valid : ls_resp_valid, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit exp_ls;
      // Reset with both requesters pushing: nothing may be granted or driven.
      if_req_valid = 1'b1; ls_req_valid = 1'b1;
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      @(posedge clk); #1;
      rst = 1'b0; preload = 1'b0;
      if_req_valid = 1'b0; ls_req_valid = 1'b0;

      // Fetch of the upper instruction half.
      issue(0, BASE + 64'h4, 0, '0, '0, 64'd0, 64'h0000_0000_1111_2222);

      // Masked store into word 2, then load back the merged word.
      issue(1, BASE + 64'h10, 1, 64'hDEAD_BEEF_0000_0000, 64'hFFFF_FFFF_0000_0000, 64'd2, 64'd0);
      issue(1, BASE + 64'h10, 0, '0, '0, 64'd2, 64'hDEAD_BEEF_89AB_CDEF);

      // Address below BASE wraps; index top bits are cleared.
      issue(0, 64'h0000_0000_7FFF_FFF8, 0, '0, '0, 64'h1FFF_FFFF_FFFF_FFFF, 64'h0000_0000_7777_8888);

      // Response backpressure with a competing fetch pending.
      @(posedge clk); #1;
      ls_resp_ready = 1'b0;
      issue(1, BASE + 64'h8, 0, '0, '0, 64'd1, W1);
      if_req_valid = 1'b1; if_req_addr = BASE;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("hold_ls_resp_valid", ls_resp_valid, 1);
         chk("hold_ls_resp_rdata", ls_resp_rdata, W1);
         chk("hold_ram_en",        ram_en,        0);
         chk("hold_if_req_ready",  if_req_ready,  0);
         chk("hold_ls_req_ready",  ls_req_ready,  0);
      end
      @(posedge clk); #1;
      if_req_valid = 1'b0; ls_resp_ready = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;

      // Reset arriving in the ACCESS cycle of a store.
      ls_req_valid = 1'b1; ls_req_addr = BASE + 64'h18; ls_req_wen = 1'b1;
      ls_req_wdata = 64'h1234_5678_9ABC_DEF0; ls_req_wmask = '1;
      @(negedge clk);
      chk("abort_ls_req_ready", ls_req_ready, 1);
      @(posedge clk); #1;
      ls_req_valid = 1'b0; rst = 1'b1;
      @(negedge clk);
      chk("abort_ram_en",  ram_en,  0);
      chk("abort_ram_wen", ram_wen, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_idle_outputs("post_abort");
      repeat (4) begin
         @(negedge clk);
         chk("abort_no_ls_resp", ls_resp_valid, 0);
      end
      chk("abort_mem_unchanged", mem[3], W3);

      // Four back-to-back transactions with both requesters always valid.
      @(posedge clk); #1;
      if_req_valid = 1'b1; if_req_addr = BASE;
      ls_req_valid = 1'b1; ls_req_addr = BASE + 64'h8; ls_req_wen = 1'b0;
      for (int k = 0; k < 4; k++) begin
`ifdef ARB_RR_EN
         exp_ls = (k % 2 == 1);
`else
         exp_ls = 1'b1;
`endif
         if (exp_ls) ls_q.push_back(W1);
         else        if_q.push_back(64'h0000_0000_3333_4444);
         @(negedge clk);
         chk("arb_if_ready", if_req_ready, !exp_ls);
         chk("arb_ls_ready", ls_req_ready, exp_ls);
         for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("arb_busy_if_ready", if_req_ready, 0);
            chk("arb_busy_ls_ready", ls_req_ready, 0);
         end
      end
      @(posedge clk); #1;
      if_req_valid = 1'b0; ls_req_valid = 1'b0;
      repeat (3) @(negedge clk);

      chk("if_queue_drained", 64'(if_q.size()), 0);
      chk("ls_queue_drained", 64'(ls_q.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
